ahb_slave_responder: RTL and testbench

AHB_SLAVE_RESPONDER -- requirements
Module: ahb_slave_responder

---
 rtl/ahb_slave_responder_pkg.sv | 52 +++++
 rtl/ahb_slave_responder_if.sv | 30 +++
 rtl/ahb_slave_responder_mem_array.sv | 43 ++++
 rtl/ahb_slave_responder.sv | 153 +++++++++++++++
 tb/tb_ahb_slave_responder.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_slave_responder_pkg.sv
// Shared AHB widths, encodings, FSM states and lane helpers for the
// ahb_slave_responder block.
package AhbGlobalPackage;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_LANES  = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } ahb_state_e;

  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] addr_lo,
                                                     input logic [2:0] size);
    logic [NUM_LANES-1:0] mask;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: mask = 4'b0011 << addr_lo;
      HSIZE_WORD: mask = 4'b1111;
      default:    mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    logic bad;
    case (size)
      HSIZE_HALF: bad = addr_lo[0];
      HSIZE_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_slave_responder_if.sv
// AHB slave-side bus bundle; the interconnect/master drives hready.
interface ahb_slave_responder_if;
  import AhbGlobalPackage::*;

  logic                  hselx;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [NUM_LANES-1:0]  hwstrb;
  logic                  hready;
  logic                  hreadyout;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hresp;
  logic                  hexokay;

  modport master (
    output hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hwstrb, hready,
    input  hreadyout, hrdata, hresp, hexokay
  );

  modport slave (
    input  hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hwstrb, hready,
    output hreadyout, hrdata, hresp, hexokay
  );

endinterface

// File: rtl/ahb_slave_responder_mem_array.sv
// Byte-enabled word storage; the read port sees a same-cycle write to the
// same word so a pipelined read returns the freshly written bytes.
module ahb_slave_mem_array
  import AhbGlobalPackage::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [NUM_LANES-1:0]  wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Per-lane write commit
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (wr_be[b]) begin
          mem_r[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read with per-lane bypass of the committing write
  always_comb begin
    rd_data = mem_r[rd_idx];
    for (int b = 0; b < NUM_LANES; b++) begin
      if (wr_en && (wr_idx == rd_idx) && wr_be[b]) begin
        rd_data[8*b +: 8] = wr_data[8*b +: 8];
      end else begin
        rd_data[8*b +: 8] = mem_r[rd_idx][8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/ahb_slave_responder.sv
// AHB-Lite memory slave: optional wait states, two-cycle ERROR response,
// pipelined back-to-back transfers with write commit in the data phase.
module ahb_slave_responder
  import AhbGlobalPackage::*;
#(
  parameter int                    MEM_DEPTH   = 256,
  parameter int                    WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                  hclk,
  input logic                  hreset,
  ahb_slave_responder_if.slave bus
);

  localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  ahb_state_e            state_r;
  logic                  hreadyout_r;
  logic                  hresp_r;
  logic [DATA_WIDTH-1:0] hrdata_r;
  logic [3:0]            wait_cnt_r;
  logic                  pend_r;
  logic                  pend_write_r;
  logic [IDX_W-1:0]      pend_idx_r;
  logic [1:0]            pend_lo_r;
  logic [2:0]            pend_size_r;

  logic                  accept_s;
  logic                  err_s;
  logic                  out_of_range_s;
  logic [ADDR_WIDTH-1:0] offset_s;
  logic [ADDR_WIDTH-1:0] word_off_s;
  logic [IDX_W-1:0]      addr_idx_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic                  wr_en_s;
  logic [NUM_LANES-1:0]  wr_be_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  unused_s;

  assign unused_s = ^{bus.hburst, bus.hprot};

  // Address-phase decode: acceptance, legality and word index
  always_comb begin
    accept_s       = bus.hselx && bus.hready &&
                     ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
    offset_s       = bus.haddr - BASE_ADDR;
    word_off_s     = offset_s >> 2;
    addr_idx_s     = word_off_s[IDX_W-1:0];
    out_of_range_s = (bus.haddr < BASE_ADDR) || (word_off_s >= ADDR_WIDTH'(MEM_DEPTH));
    err_s          = (bus.hsize > HSIZE_WORD) || misaligned(bus.haddr[1:0], bus.hsize) ||
                     out_of_range_s;
  end

  // Storage port control; a pending write commits at the end of its OKAY cycle
  always_comb begin
    wr_en_s = (state_r == ST_READY) && pend_r && pend_write_r && !hreset;
    wr_be_s = lane_mask(pend_lo_r, pend_size_r) & bus.hwstrb;
    if (state_r == ST_WAIT) begin
      rd_idx_s = pend_idx_r;
    end else begin
      rd_idx_s = addr_idx_s;
    end
  end

  ahb_slave_mem_array #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk     (hclk),
    .wr_en   (wr_en_s),
    .wr_idx  (pend_idx_r),
    .wr_be   (wr_be_s),
    .wr_data (bus.hwdata),
    .rd_idx  (rd_idx_s),
    .rd_data (rd_data_s)
  );

  // Transfer FSM with registered bus responses
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_r      <= ST_READY;
      hreadyout_r  <= 1'b1;
      hresp_r      <= HRESP_OKAY;
      hrdata_r     <= {DATA_WIDTH{1'b0}};
      wait_cnt_r   <= 4'd0;
      pend_r       <= 1'b0;
      pend_write_r <= 1'b0;
      pend_idx_r   <= {IDX_W{1'b0}};
      pend_lo_r    <= 2'b00;
      pend_size_r  <= 3'b000;
    end else begin
      hrdata_r <= {DATA_WIDTH{1'b0}};
      case (state_r)
        ST_READY, ST_ERR2: begin
          pend_r      <= 1'b0;
          state_r     <= ST_READY;
          hreadyout_r <= 1'b1;
          hresp_r     <= HRESP_OKAY;
          if (accept_s) begin
            pend_write_r <= bus.hwrite;
            pend_idx_r   <= addr_idx_s;
            pend_lo_r    <= bus.haddr[1:0];
            pend_size_r  <= bus.hsize;
            if (err_s) begin
              state_r     <= ST_ERR1;
              hreadyout_r <= 1'b0;
              hresp_r     <= HRESP_ERROR;
            end else if (WAIT_STATES == 0) begin
              pend_r <= 1'b1;
              if (!bus.hwrite) begin
                hrdata_r <= rd_data_s;
              end
            end else begin
              state_r     <= ST_WAIT;
              hreadyout_r <= 1'b0;
              wait_cnt_r  <= WAIT_LOAD;
              pend_r      <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == 4'd0) begin
            state_r     <= ST_READY;
            hreadyout_r <= 1'b1;
            if (!pend_write_r) begin
              hrdata_r <= rd_data_s;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_ERR1: begin
          state_r     <= ST_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= HRESP_ERROR;
        end
        default: begin
          state_r     <= ST_READY;
          hreadyout_r <= 1'b1;
          hresp_r     <= HRESP_OKAY;
          pend_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hreadyout = hreadyout_r;
  assign bus.hresp     = hresp_r;
  assign bus.hrdata    = hrdata_r;
  assign bus.hexokay   = 1'b0;

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Scoreboard bench: three responders (0, 2, 3 wait states) share one
// stimulus driver; a bus monitor pops expected responses on completion.
module tb_ahb_slave_responder;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          waits;
  } exp_t;

  logic        hclk;
  logic        hreset;
  logic        hsel_drv;
  logic [31:0] haddr_drv;
  logic [1:0]  htrans_drv;
  logic        hwrite_drv;
  logic [2:0]  hsize_drv;
  logic [31:0] hwdata_drv;
  logic [3:0]  hwstrb_drv;
  logic        block_rdy;
  int          sel;

  logic        rdy_v  [3];
  logic        hrdy_v [3];
  logic        resp_v [3];
  logic        exo_v  [3];
  logic [31:0] rd_v   [3];

  logic        m_rdy, m_hrdy, m_resp;
  logic [31:0] m_rd;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_slave_responder_if bus();
    assign bus.hselx  = hsel_drv && (sel == g);
    assign bus.haddr  = haddr_drv;
    assign bus.htrans = htrans_drv;
    assign bus.hwrite = hwrite_drv;
    assign bus.hsize  = hsize_drv;
    assign bus.hburst = 3'b000;
    assign bus.hprot  = 4'b0011;
    assign bus.hwdata = hwdata_drv;
    assign bus.hwstrb = hwstrb_drv;
    assign bus.hready = bus.hreadyout && !block_rdy;
    assign rdy_v[g]   = bus.hreadyout;
    assign hrdy_v[g]  = bus.hready;
    assign resp_v[g]  = bus.hresp;
    assign exo_v[g]   = bus.hexokay;
    assign rd_v[g]    = bus.hrdata;

    ahb_slave_responder #(
      .MEM_DEPTH   (256),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
      .BASE_ADDR   (32'h0000_0000)
    ) u_dut (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus)
    );
  end

  assign m_rdy  = rdy_v[sel];
  assign m_hrdy = hrdy_v[sel];
  assign m_resp = resp_v[sel];
  assign m_rd   = rd_v[sel];

  function automatic int ws_cur();
    return (sel == 0) ? 0 : ((sel == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (dut %0d, t=%0t)", name, got, exp, sel, $time);
    end
  endtask

  // Drive one address phase, queue its expected response, return once accepted.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic exp_resp, input logic [31:0] exp_rdata, input int exp_waits);
    exp_t e;
    int   budget;
    hsel_drv   = 1'b1;
    htrans_drv = 2'b10;
    hwrite_drv = wr;
    haddr_drv  = addr;
    hsize_drv  = size;
    e.resp  = exp_resp;
    e.rdata = exp_rdata;
    e.waits = exp_waits;
    sb_q.push_back(e);
    budget = 0;
    @(negedge hclk);
    while (!m_hrdy && budget < 50) begin
      budget++;
      @(negedge hclk);
    end
    if (!m_hrdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: addr %h never accepted", addr);
    end
    @(posedge hclk);
    #1;
    hwdata_drv = wdata;
    hwstrb_drv = strb;
    hsel_drv   = 1'b0;
    htrans_drv = 2'b00;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [2:0] size,
                    input logic [31:0] data, input logic [3:0] strb);
    issue(1'b1, addr, size, data, strb, 1'b0, 32'h0000_0000, ws_cur());
  endtask

  task automatic rd(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] exp);
    issue(1'b0, addr, size, 32'h0000_0000, 4'h0, 1'b0, exp, ws_cur());
  endtask

  task automatic er(input logic w, input logic [31:0] addr, input logic [2:0] size,
                    input logic [31:0] data);
    issue(w, addr, size, data, 4'hF, 1'b1, 32'h0000_0000, 1);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb_q.size() != 0 && b < 100) begin
      @(posedge hclk);
      #1;
      b++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", sb_q.size());
    end
    repeat (2) begin
      @(posedge hclk);
      #1;
    end
  endtask

  // Bus monitor: tracks data phases from observed address acceptance.
  initial begin : monitor
    logic dp_active;
    int   low_cnt;
    exp_t e;
    dp_active = 1'b0;
    low_cnt   = 0;
    forever begin
      @(negedge hclk);
      if (hreset) begin
        dp_active = 1'b0;
        low_cnt   = 0;
        sb_q.delete();
      end else begin
        if (dp_active) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dataphase: no expected entry at t=%0t", $time);
          end else if (!m_rdy) begin
            low_cnt++;
            chk("wait_hresp", {31'd0, m_resp}, {31'd0, sb_q[0].resp});
            chk("wait_hrdata", m_rd, 32'h0000_0000);
          end else begin
            e = sb_q.pop_front();
            chk("hresp", {31'd0, m_resp}, {31'd0, e.resp});
            chk("hrdata", m_rd, e.rdata);
            chk("wait_cycles", 32'(low_cnt), 32'(e.waits));
            low_cnt = 0;
          end
        end
        if (!(dp_active && !m_hrdy)) begin
          dp_active = hsel_drv && m_hrdy && htrans_drv[1];
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    hreset     = 1'b1;
    hsel_drv   = 1'b0;
    haddr_drv  = 32'h0000_0000;
    htrans_drv = 2'b00;
    hwrite_drv = 1'b0;
    hsize_drv  = 3'd2;
    hwdata_drv = 32'h0000_0000;
    hwstrb_drv = 4'h0;
    block_rdy  = 1'b0;
    sel        = 0;
    repeat (3) @(posedge hclk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_hreadyout", {31'd0, rdy_v[g]}, 32'd1);
      chk("rst_hresp", {31'd0, resp_v[g]}, 32'd0);
      chk("rst_hrdata", rd_v[g], 32'h0000_0000);
      chk("rst_hexokay", {31'd0, exo_v[g]}, 32'd0);
    end
    hreset = 1'b0;

    // Zero wait states: pipelined write/read, lane merging, errors
    wr(32'h10, 3'd2, 32'hDEAD_BEEF, 4'hF);
    rd(32'h10, 3'd2, 32'hDEAD_BEEF);
    drain();
    wr(32'h20, 3'd2, 32'h1122_3344, 4'hF);
    wr(32'h21, 3'd0, 32'h5A5A_A55A, 4'hF);
    rd(32'h20, 3'd2, 32'h1122_A544);
    wr(32'h22, 3'd1, 32'hBEEF_0000, 4'hF);
    rd(32'h20, 3'd2, 32'hBEEF_A544);
    wr(32'h20, 3'd2, 32'h0000_0000, 4'h1);
    rd(32'h20, 3'd2, 32'hBEEF_A500);
    rd(32'h23, 3'd0, 32'hBEEF_A500);
    drain();
    er(1'b0, 32'h02, 3'd2, 32'h0000_0000);
    er(1'b0, 32'h08, 3'd3, 32'h0000_0000);
    er(1'b0, 32'h21, 3'd1, 32'h0000_0000);
    drain();
    wr(32'h00, 3'd2, 32'hCAFE_0001, 4'hF);
    er(1'b1, 32'h400, 3'd2, 32'hFFFF_FFFF);
    rd(32'h00, 3'd2, 32'hCAFE_0001);
    drain();

    // hready low from elsewhere, then BUSY: neither may start a transfer
    block_rdy  = 1'b1;
    hsel_drv   = 1'b1;
    htrans_drv = 2'b10;
    hwrite_drv = 1'b0;
    haddr_drv  = 32'h02;
    hsize_drv  = 3'd2;
    @(posedge hclk);
    #1;
    block_rdy  = 1'b0;
    htrans_drv = 2'b01;
    @(posedge hclk);
    #1;
    hsel_drv   = 1'b0;
    htrans_drv = 2'b00;
    @(negedge hclk);
    chk("noaccept_hreadyout", {31'd0, m_rdy}, 32'd1);
    chk("noaccept_hresp", {31'd0, m_resp}, 32'd0);
    chk("noaccept_hrdata", m_rd, 32'h0000_0000);
    @(posedge hclk);
    #1;

    // Two wait states
    sel = 1;
    wr(32'h04, 3'd2, 32'h1234_5678, 4'hF);
    rd(32'h04, 3'd2, 32'h1234_5678);
    er(1'b0, 32'h06, 3'd2, 32'h0000_0000);
    drain();

    // Three wait states: reset during the wait of a write discards it
    sel = 2;
    wr(32'h08, 3'd2, 32'hAAAA_5555, 4'hF);
    drain();
    wr(32'h08, 3'd2, 32'h0BAD_0BAD, 4'hF);
    hreset = 1'b1;
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(negedge hclk);
    chk("midwait_rst_hreadyout", {31'd0, m_rdy}, 32'd1);
    chk("midwait_rst_hresp", {31'd0, m_resp}, 32'd0);
    @(posedge hclk);
    #1;
    rd(32'h08, 3'd2, 32'hAAAA_5555);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
